// File: rtl/vga_sink_pkg.sv
// rtl/vga_sink_pkg.sv - shared state encoding and defaults for the VGA sink monitor
package vga_sink_pkg;

    localparam int CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - registered single-edge detector on an already-registered level
module vga_edge_det #(
    parameter bit RISING = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign pulse = RISING ? (level & ~level_prev) : (level_prev & ~level);

endmodule

// File: rtl/vga_sink_monitor.sv
// rtl/vga_sink_monitor.sv - VGA timing measurement, pixel coordinates, lit bbox and lock tracking
module vga_sink_monitor
    import vga_sink_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [2:0]       VGA_R,
    input  logic [2:0]       VGA_G,
    input  logic [1:0]       VGA_B,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic             VGA_BLANK_N,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_valid,
    output logic             pix_lit,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] bbox_x0,
    output logic [CNT_W-1:0] bbox_y0,
    output logic [CNT_W-1:0] bbox_x1,
    output logic [CNT_W-1:0] bbox_y1,
    output logic             bbox_valid,
    output logic             frame_done,
    output logic             locked,
    output logic             err
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t LOCK_TGT = cnt_t'(LOCK_FRAMES - 1);

    logic       hs_q, vs_q, blank_q;
    logic [7:0] rgb_q;
    logic       hs_fall, vs_fall, blank_fall;

    mon_state_t state, state_next;
    cnt_t       match_cnt, match_next;
    logic       lock_err;

    cnt_t x_cnt, y_cnt, h_cnt, h_tot_line, h_act_line;
    cnt_t bb_x0, bb_y0, bb_x1, bb_y1;
    logic bb_any, sat_seen;

    cnt_t x_base, x_next, y_base, y_inc;
    cnt_t h_tot_now, h_act_now, v_act_now;
    logic x_sat, y_sat, h_sat, cur_lit, same, sat_err, frame_end;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hs_q    <= VGA_HS;
            vs_q    <= VGA_VS;
            blank_q <= VGA_BLANK_N;
            rgb_q   <= {VGA_R, VGA_G, VGA_B};
        end
    end

    vga_edge_det #(.RISING(1'b0)) u_hs_edge    (.clk(sys_clk), .rst(rst), .level(hs_q),    .pulse(hs_fall));
    vga_edge_det #(.RISING(1'b0)) u_vs_edge    (.clk(sys_clk), .rst(rst), .level(vs_q),    .pulse(vs_fall));
    vga_edge_det #(.RISING(1'b0)) u_blank_edge (.clk(sys_clk), .rst(rst), .level(blank_q), .pulse(blank_fall));

    // The *_now values fold in this cycle's edges so a frame start coinciding with a line end snapshots the finished line.
    always_comb begin
        x_base    = hs_fall ? '0 : x_cnt;
        x_sat     = blank_q && (x_base == CNT_MAX);
        x_next    = blank_q ? (x_sat ? CNT_MAX : x_base + 1'b1) : x_base;
        y_base    = vs_fall ? '0 : y_cnt;
        y_sat     = blank_fall && (y_cnt == CNT_MAX);
        y_inc     = y_sat ? CNT_MAX : y_cnt + 1'b1;
        h_sat     = !hs_fall && (h_cnt == CNT_MAX);
        h_tot_now = hs_fall ? h_cnt : h_tot_line;
        h_act_now = blank_fall ? x_cnt : h_act_line;
        v_act_now = blank_fall ? y_inc : y_cnt;
        cur_lit   = blank_q && (rgb_q != 8'd0);
        same      = (h_act_now == h_active) && (v_act_now == v_active) && (h_tot_now == h_total);
        frame_end = vs_fall && (state != ST_IDLE);
        sat_err   = (x_sat || y_sat || h_sat) && !(sat_seen && !vs_fall) && (state != ST_IDLE);
    end

    always_comb begin
        state_next = state;
        match_next = match_cnt;
        lock_err   = 1'b0;
        if (vs_fall) begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_ACQUIRE;
                    match_next = '0;
                end
                ST_ACQUIRE: begin
                    match_next = same ? match_cnt + 1'b1 : '0;
                    if (match_next >= LOCK_TGT) begin
                        state_next = ST_LOCKED;
                        match_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!same) begin
                        state_next = ST_ACQUIRE;
                        match_next = '0;
                        lock_err   = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            match_cnt  <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            h_cnt      <= '0;
            h_tot_line <= '0;
            h_act_line <= '0;
            bb_any     <= 1'b0;
            bb_x0      <= '0;
            bb_y0      <= '0;
            bb_x1      <= '0;
            bb_y1      <= '0;
            sat_seen   <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_valid  <= 1'b0;
            pix_lit    <= 1'b0;
            h_active   <= '0;
            v_active   <= '0;
            h_total    <= '0;
            bbox_x0    <= '0;
            bbox_y0    <= '0;
            bbox_x1    <= '0;
            bbox_y1    <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            match_cnt  <= match_next;
            x_cnt      <= x_next;
            y_cnt      <= vs_fall ? '0 : (blank_fall ? y_inc : y_cnt);
            h_cnt      <= hs_fall ? cnt_t'(1) : (h_sat ? CNT_MAX : h_cnt + 1'b1);
            h_tot_line <= h_tot_now;
            h_act_line <= h_act_now;
            sat_seen   <= (sat_seen && !vs_fall) || x_sat || y_sat || h_sat;

            pix_valid <= blank_q;
            pix_lit   <= cur_lit;
            if (blank_q) begin
                pix_x <= x_base;
                pix_y <= y_base;
            end

            // A pixel on the frame-start cycle already belongs to the new frame.
            if (vs_fall) begin
                bb_any <= cur_lit;
                bb_x0  <= x_base;
                bb_x1  <= x_base;
                bb_y0  <= y_base;
                bb_y1  <= y_base;
            end else if (cur_lit) begin
                bb_any <= 1'b1;
                if (!bb_any || x_base < bb_x0) bb_x0 <= x_base;
                if (!bb_any || x_base > bb_x1) bb_x1 <= x_base;
                if (!bb_any || y_base < bb_y0) bb_y0 <= y_base;
                if (!bb_any || y_base > bb_y1) bb_y1 <= y_base;
            end

            frame_done <= frame_end;
            if (frame_end) begin
                h_active   <= h_act_now;
                v_active   <= v_act_now;
                h_total    <= h_tot_now;
                bbox_valid <= bb_any;
                if (bb_any) begin
                    bbox_x0 <= bb_x0;
                    bbox_y0 <= bb_y0;
                    bbox_x1 <= bb_x1;
                    bbox_y1 <= bb_y1;
                end
            end

            err <= lock_err || sat_err;
        end
    end

endmodule
